ctrl_mem_arb: RTL and testbench

Arbiter and sequencer for the single-port instruction/data memory shared by the IF stage (instruction fetch) and the MEM stage (LDR/STR data access).
- Serialises both requesters onto one memory port with fixed read latency; one transaction outstanding at a time.
- Returns read data to the owning requester.
- Generates the pipeline stall consumed by the stage control blocks while a data access is pending.

---
 rtl/ctrl_mem_arb.sv | 145 ++++++++++++++
 tb/tb_ctrl_mem_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mem_arb.sv
// rtl/ctrl_mem_arb.sv - Fetch/data arbiter and sequencer for the shared single-port memory
module ctrl_mem_arb #(
    parameter int ADDR_W     = 16,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_valid,
    output logic [15:0]       o_if_data,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [15:0]       i_dm_wdata,
    output logic              o_dm_valid,
    output logic [15:0]       o_dm_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_stall
);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam int ST_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(LAT);
    localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic              owner_dm, owner_dm_nxt;
    logic              cur_we, cur_we_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ST_W-1:0]   starve, starve_nxt;
    logic              if_valid_nxt, dm_valid_nxt, mem_en_nxt, mem_we_nxt;
    logic [15:0]       if_data_nxt, dm_rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              grant_dm, grant_if;

    // Data normally wins; a fetch that has watched STARVE_MAX data grants in a row is forced through.
    assign grant_dm = i_dm_req & ~(i_if_req & (starve == STARVE_LIM));
    assign grant_if = i_if_req & ~grant_dm;
    assign o_stall  = i_dm_req & ~o_dm_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_dm    <= 1'b0;
            cur_we      <= 1'b0;
            wait_cnt    <= '0;
            starve      <= '0;
            o_if_valid  <= 1'b0;
            o_if_data   <= '0;
            o_dm_valid  <= 1'b0;
            o_dm_rdata  <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            state       <= state_nxt;
            owner_dm    <= owner_dm_nxt;
            cur_we      <= cur_we_nxt;
            wait_cnt    <= wait_cnt_nxt;
            starve      <= starve_nxt;
            o_if_valid  <= if_valid_nxt;
            o_if_data   <= if_data_nxt;
            o_dm_valid  <= dm_valid_nxt;
            o_dm_rdata  <= dm_rdata_nxt;
            o_mem_en    <= mem_en_nxt;
            o_mem_we    <= mem_we_nxt;
            o_mem_addr  <= mem_addr_nxt;
            o_mem_wdata <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_dm | grant_if) state_nxt = ISSUE;
            ISSUE:   state_nxt = cur_we ? RESP : WAIT;
            WAIT:    if (wait_cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        owner_dm_nxt  = owner_dm;
        cur_we_nxt    = cur_we;
        wait_cnt_nxt  = wait_cnt;
        starve_nxt    = starve;
        if_valid_nxt  = 1'b0;
        dm_valid_nxt  = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = o_mem_addr;
        mem_wdata_nxt = o_mem_wdata;
        if_data_nxt   = o_if_data;
        dm_rdata_nxt  = o_dm_rdata;
        case (state)
            IDLE: begin
                if (grant_dm) begin
                    owner_dm_nxt  = 1'b1;
                    cur_we_nxt    = i_dm_we;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = i_dm_we;
                    mem_addr_nxt  = i_dm_addr;
                    mem_wdata_nxt = i_dm_wdata;
                    if (!i_if_req)
                        starve_nxt = '0;
                    else if (starve != STARVE_LIM)
                        starve_nxt = starve + ST_W'(1);
                end else if (grant_if) begin
                    owner_dm_nxt = 1'b0;
                    cur_we_nxt   = 1'b0;
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = i_if_addr;
                    starve_nxt   = '0;
                end
            end
            ISSUE: begin
                wait_cnt_nxt = LAT_LOAD;
                if (cur_we) dm_valid_nxt = 1'b1;
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt - CNT_W'(1);
                // Read data is valid on the port only in the final wait cycle.
                if (wait_cnt == CNT_W'(1)) begin
                    if (owner_dm) begin
                        dm_rdata_nxt = i_mem_rdata;
                        dm_valid_nxt = 1'b1;
                    end else begin
                        if_data_nxt  = i_mem_rdata;
                        if_valid_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ctrl_mem_arb.sv
// tb/tb_ctrl_mem_arb.sv - Scoreboard bench for ctrl_mem_arb
module tb_ctrl_mem_arb;
    localparam int ADDR_W     = 16;
    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req = 1'b0;
    logic [15:0] i_if_addr = '0;
    logic        o_if_valid;
    logic [15:0] o_if_data;
    logic        i_dm_req = 1'b0;
    logic        i_dm_we = 1'b0;
    logic [15:0] i_dm_addr = '0;
    logic [15:0] i_dm_wdata = '0;
    logic        o_dm_valid;
    logic [15:0] o_dm_rdata;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] i_mem_rdata;
    logic        o_stall;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [15:0] if_exp_q[$];
    logic [15:0] dm_exp_q[$];
    int          due_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] exp_last_rd = '0;

    ctrl_mem_arb #(.ADDR_W(ADDR_W), .LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_valid(o_if_valid), .o_if_data(o_if_data),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_stall(o_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA5A5;
        if (a == 16'h0200) return 16'h5A5A;
        return (a * 16'h1357) ^ 16'hBEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_if(input logic [15:0] a);
        i_if_addr = a;
        i_if_req  = 1'b1;
        if_exp_q.push_back(init_val(a));
    endtask

    // A store leaves o_dm_rdata at the last load's value.
    task automatic issue_dm(input logic we, input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] v;
        i_dm_we    = we;
        i_dm_addr  = a;
        i_dm_wdata = wd;
        i_dm_req   = 1'b1;
        if (we) begin
            ref_mem[int'(a)] = wd;
            dm_exp_q.push_back(exp_last_rd);
        end else begin
            v = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
            dm_exp_q.push_back(v);
            exp_last_rd = v;
        end
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        if_exp_q.delete();
        dm_exp_q.delete();
        exp_last_rd = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_if_valid"}, o_if_valid, 0);
        chk({tag, "_if_data"}, o_if_data, 0);
        chk({tag, "_dm_valid"}, o_dm_valid, 0);
        chk({tag, "_dm_rdata"}, o_dm_rdata, 0);
        chk({tag, "_mem_en"}, o_mem_en, 0);
        chk({tag, "_mem_we"}, o_mem_we, 0);
        chk({tag, "_mem_addr"}, o_mem_addr, 0);
        chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    endtask

    // Fetch 0x0010 and load 0x0200 raised together in cycle 0.
    task automatic dual_run(input string tag);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk({tag, "_mem_en"}, o_mem_en, (k == 1) || (k == 6));
            if (k == 1) chk({tag, "_addr_d"}, o_mem_addr, 16'h0200);
            if (k == 6) chk({tag, "_addr_f"}, o_mem_addr, 16'h0010);
            chk({tag, "_dm_valid"}, o_dm_valid, k == 4);
            chk({tag, "_if_valid"}, o_if_valid, k == 9);
            chk({tag, "_stall"}, o_stall, k < 4);
            tick();
            if (k == 4) i_dm_req = 1'b0;
            if (k == 9) i_if_req = 1'b0;
        end
    endtask

    task automatic wait_valid(input bit is_dm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_dm ? o_dm_valid : o_if_valid) && n < 300);
        if (is_dm) chk("dm_wait_bound", o_dm_valid, 1);
        else       chk("if_wait_bound", o_if_valid, 1);
    endtask

    task automatic run_if(input int n);
        for (int t = 0; t < n; t++) begin
            i_if_req = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            issue_if(16'($urandom_range(0, 255)));
            wait_valid(1'b0);
            tick();
        end
        i_if_req = 1'b0;
    endtask

    task automatic run_dm(input int n);
        for (int t = 0; t < n; t++) begin
            i_dm_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            issue_dm(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom));
            wait_valid(1'b1);
            tick();
        end
        i_dm_req = 1'b0;
    endtask

    // Memory: stores land on the issue cycle, reads appear exactly LAT cycles after issue, noise otherwise.
    initial begin : mem_model
        logic [15:0] mem_a[int];
        int rd_a[$];
        int rd_due[$];
        i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (o_mem_en) begin
                if (o_mem_we) mem_a[int'(o_mem_addr)] = o_mem_wdata;
                else begin
                    rd_a.push_back(int'(o_mem_addr));
                    rd_due.push_back(cycle + LAT);
                end
            end
            @(posedge clk);
            #1;
            if (rd_due.size() > 0 && rd_due[0] == cycle) begin
                i_mem_rdata = mem_a.exists(rd_a[0]) ? mem_a[rd_a[0]] : init_val(16'(rd_a[0]));
                void'(rd_a.pop_front());
                void'(rd_due.pop_front());
            end else begin
                i_mem_rdata = 16'($urandom);
            end
        end
    end

    initial begin : monitor
        int   st = 0;
        logic p_if = 1'b0;
        logic p_dm = 1'b0;
        logic prev_ifv = 1'b0;
        logic prev_dmv = 1'b0;
        logic is_fetch;
        logic exp_fetch;
        forever begin
            @(negedge clk);
            if (rst) begin
                st = 0;
                due_q.delete();
            end else begin
                if (o_mem_en) begin
                    chk("one_outstanding", due_q.size(), 0);
                    chk("issue_had_req", p_if | p_dm, 1);
                    is_fetch  = o_mem_addr < 16'h0100;
                    exp_fetch = p_if && (!p_dm || st >= STARVE_MAX);
                    chk("grant_is_fetch", is_fetch, exp_fetch);
                    if (is_fetch || !p_if) st = 0;
                    else if (st < STARVE_MAX) st = st + 1;
                    due_q.push_back(o_mem_we ? cycle + 1 : cycle + LAT + 1);
                end
                if (o_if_valid) begin
                    chk("if_valid_pulse", prev_ifv, 0);
                    chk("if_valid_expected", if_exp_q.size() > 0, 1);
                    if (if_exp_q.size() > 0) chk("if_data", o_if_data, if_exp_q.pop_front());
                    chk("if_valid_issued", due_q.size() > 0, 1);
                    if (due_q.size() > 0) chk("if_latency", cycle, due_q.pop_front());
                end
                if (o_dm_valid) begin
                    chk("dm_valid_pulse", prev_dmv, 0);
                    chk("dm_valid_expected", dm_exp_q.size() > 0, 1);
                    if (dm_exp_q.size() > 0) chk("dm_rdata", o_dm_rdata, dm_exp_q.pop_front());
                    chk("dm_valid_issued", due_q.size() > 0, 1);
                    if (due_q.size() > 0) chk("dm_latency", cycle, due_q.pop_front());
                end
                chk("stall", o_stall, i_dm_req & ~o_dm_valid);
            end
            p_if = i_if_req;
            p_dm = i_dm_req;
            prev_ifv = o_if_valid;
            prev_dmv = o_dm_valid;
        end
    end

    initial begin
        string seq;
        int    nld;
        logic  dv, iv;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;

        issue_if(16'h0010);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_mem_en", o_mem_en, k == 1);
            if (k == 1) chk("t1_mem_addr", o_mem_addr, 16'h0010);
            chk("t1_if_valid", o_if_valid, k == 4);
            if (k == 4) chk("t1_if_data", o_if_data, 16'hA5A5);
            tick();
            if (k == 4) i_if_req = 1'b0;
        end

        issue_if(16'h0010);
        issue_dm(1'b0, 16'h0200, 16'h0000);
        dual_run("t2");

        issue_dm(1'b1, 16'h0300, 16'h1234);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_mem_en", o_mem_en, k == 1);
            chk("t3_mem_we", o_mem_we, k == 1);
            if (k == 1) chk("t3_mem_addr", o_mem_addr, 16'h0300);
            if (k == 1) chk("t3_mem_wdata", o_mem_wdata, 16'h1234);
            chk("t3_dm_valid", o_dm_valid, k == 2);
            chk("t3_rdata_kept", o_dm_rdata, 16'h5A5A);
            tick();
            if (k == 2) i_dm_req = 1'b0;
        end

        seq = "";
        issue_if(16'h0020);
        issue_dm(1'b0, 16'h0100, 16'h0000);
        nld = 1;
        for (int k = 0; k < 150 && (i_if_req || i_dm_req); k++) begin
            @(negedge clk);
            if (o_mem_en) begin
                if (o_mem_addr < 16'h0100) seq = {seq, "F"};
                else seq = {seq, "D"};
            end
            dv = o_dm_valid;
            iv = o_if_valid;
            tick();
            if (iv) i_if_req = 1'b0;
            if (dv) begin
                if (nld < 5) begin
                    issue_dm(1'b0, 16'h0100 + 16'(nld), 16'h0000);
                    nld++;
                end else i_dm_req = 1'b0;
            end
        end
        chk("t4_done", i_if_req | i_dm_req, 0);
        checks++;
        if (seq != "DDDDFD") begin
            errors++;
            $display("FAIL t4_grant_seq: got %s expected DDDDFD", seq);
        end

        issue_dm(1'b0, 16'h0200, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_mem_en", o_mem_en, k == 1);
            tick();
        end
        assert_rst();
        i_dm_req = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("t5");
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            chk("t5_no_valid", o_dm_valid, 0);
        end
        tick();
        issue_dm(1'b0, 16'h0300, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5b_mem_en", o_mem_en, k == 1);
            chk("t5b_dm_valid", o_dm_valid, k == 4);
            if (k == 4) chk("t5b_rdata", o_dm_rdata, 16'h1234);
            tick();
            if (k == 4) i_dm_req = 1'b0;
        end

        assert_rst();
        i_if_req  = 1'b1;
        i_if_addr = 16'h0010;
        i_dm_req  = 1'b1;
        i_dm_we   = 1'b0;
        i_dm_addr = 16'h0200;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_en_in_rst", o_mem_en, 0);
            tick();
        end
        rst = 1'b0;
        issue_if(16'h0010);
        issue_dm(1'b0, 16'h0200, 16'h0000);
        dual_run("t6");

        fork
            run_if(40);
            run_dm(40);
        join
        repeat (8) tick();
        chk("if_queue_drained", if_exp_q.size(), 0);
        chk("dm_queue_drained", dm_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
